// File: rtl/ft2_fifo_arbiter.sv
// FT245-style FIFO bus arbiter: alternates host reads and writes over one shared
// data bus with programmable strobe widths and recovery gaps.
module ft2_fifo_arbiter #(
    parameter int unsigned RD_WAIT  = 3,
    parameter int unsigned WR_HOLD  = 3,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxf_n_in,
    input  logic       txe_n_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       rd_n_out,
    output logic       wr_n_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_RECOVER,
        WR_SETUP,
        WR_STROBE,
        WR_RECOVER
    } state_t;

    localparam logic [3:0] RD_LAST  = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST  = 4'(WR_HOLD - 1);
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_wr_q, last_wr_d;
    logic       rxf_meta_q, rxf_meta_d, rxf_s_q, rxf_s_d;
    logic       txe_meta_q, txe_meta_d, txe_s_q, txe_s_d;
    logic       rd_elig, wr_elig;

    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       d_oe_q, d_oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            rxf_meta_q <= 1'b1;
            rxf_s_q    <= 1'b1;
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            d_oe_q     <= 1'b0;
            d_out_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            rxf_meta_q <= rxf_meta_d;
            rxf_s_q    <= rxf_s_d;
            txe_meta_q <= txe_meta_d;
            txe_s_q    <= txe_s_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        rxf_meta_d = rxf_n_in;
        rxf_s_d    = rxf_meta_q;
        txe_meta_d = txe_n_in;
        txe_s_d    = txe_meta_q;
        rd_elig    = !rxf_s_q;
        wr_elig    = !txe_s_q && tx_valid;
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        cnt_d      = cnt_q + 4'd1;
        case (state_q)
            IDLE: begin
                // On contention the side not served last time wins.
                if (rd_elig && (!wr_elig || last_wr_q)) begin
                    state_d   = RD_STROBE;
                    last_wr_d = 1'b0;
                end else if (wr_elig) begin
                    state_d   = WR_SETUP;
                    last_wr_d = 1'b1;
                end
            end
            RD_STROBE:  if (cnt_q == RD_LAST)  state_d = RD_RECOVER;
            RD_RECOVER: if (cnt_q == GAP_LAST) state_d = IDLE;
            WR_SETUP:                          state_d = WR_STROBE;
            WR_STROBE:  if (cnt_q == WR_LAST)  state_d = WR_RECOVER;
            WR_RECOVER: if (cnt_q == GAP_LAST) state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        rd_n_d     = (state_d != RD_STROBE);
        wr_n_d     = (state_d != WR_STROBE);
        d_oe_d     = (state_d == WR_SETUP) || (state_d == WR_STROBE) ||
                     ((state_d == WR_RECOVER) && (cnt_d == 4'd0));
        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_q == IDLE) && (state_d == WR_SETUP);
        rx_valid_d = (state_q == RD_STROBE) && (state_d == RD_RECOVER);
        d_out_d    = tx_ready_d ? tx_data : d_out_q;
        rx_data_d  = rx_valid_d ? d_in : rx_data_q;
    end

    assign rd_n_out = rd_n_q;
    assign wr_n_out = wr_n_q;
    assign d_oe     = d_oe_q;
    assign d_out    = d_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule
